// File: rtl/jtdsp16_prog_seq.sv
// DSP16 program sequencer: fetch address generation with a
// hardware return stack, nested DO loops and one-level interrupt shadow.
module jtdsp16_prog_seq #(
  parameter int AW          = 16,
  parameter int STACK_DEPTH = 4,
  parameter int LOOP_DEPTH  = 2,
  parameter int CNTW        = 7,
  parameter int LENW        = 4,
  parameter int RST_VEC     = 0,
  parameter int IRQ_VEC     = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                cen,
  input  logic                                halt,
  input  logic                                jump,
  input  logic                                call,
  input  logic                                ret,
  input  logic                                iret,
  input  logic [AW-1:0]                       tgt,
  input  logic                                do_start,
  input  logic [LENW-1:0]                     do_len,
  input  logic [CNTW-1:0]                     do_cnt,
  input  logic                                irq,
  input  logic                                no_int,
  input  logic                                err_clr,
  output logic [AW-1:0]                       pc,
  output logic [AW-1:0]                       pi,
  output logic                                iack,
  output logic                                in_irq,
  output logic [$clog2(STACK_DEPTH+1)-1:0]    sp,
  output logic [$clog2(LOOP_DEPTH+1)-1:0]     loop_lvl,
  output logic                                stk_ovf,
  output logic                                stk_unf,
  output logic                                loop_ovf
);
  localparam int SPW = $clog2(STACK_DEPTH+1);
  localparam int LVW = $clog2(LOOP_DEPTH+1);

  logic [AW-1:0]   pc_q, pc_d, pi_q, pi_d;
  logic            iack_q, iack_d, in_irq_q, in_irq_d;
  logic [SPW-1:0]  sp_q, sp_d;
  logic [LVW-1:0]  lvl_q, lvl_d;
  logic            stk_ovf_q, stk_ovf_d;
  logic            stk_unf_q, stk_unf_d;
  logic            loop_ovf_q, loop_ovf_d;
  logic [AW-1:0]   stk_q [STACK_DEPTH];
  logic [AW-1:0]   stk_d [STACK_DEPTH];
  logic [AW-1:0]   head_q [LOOP_DEPTH];
  logic [AW-1:0]   head_d [LOOP_DEPTH];
  logic [AW-1:0]   end_q [LOOP_DEPTH];
  logic [AW-1:0]   end_d [LOOP_DEPTH];
  logic [CNTW-1:0] cnt_q [LOOP_DEPTH];
  logic [CNTW-1:0] cnt_d [LOOP_DEPTH];

  logic [AW-1:0]   seq, npc, top, redir_pc;
  logic            redir, chain;
  logic            so_set, su_set, lo_set;
  logic [LENW-1:0] len;
  logic [CNTW-1:0] cnt1;

  always_comb begin
    seq        = pc_q + AW'(1);
    pi_d       = pi_q;
    iack_d     = 1'b0;
    in_irq_d   = in_irq_q;
    sp_d       = sp_q;
    stk_d      = stk_q;
    head_d     = head_q;
    end_d      = end_q;
    cnt_d      = cnt_q;
    so_set     = 1'b0;
    su_set     = 1'b0;
    lo_set     = 1'b0;
    redir      = 1'b0;
    redir_pc   = '0;
    top        = '0;
    len        = (do_len == '0) ? LENW'(1) : do_len;
    cnt1       = (do_cnt == '0) ? CNTW'(1) : do_cnt;
    for (int i = 0; i < STACK_DEPTH; i++)
      if (SPW'(i + 1) == sp_q) top = stk_q[i];

    // Walk down the loop stack while entries share this end address
    lvl_d = lvl_q;
    chain = !halt;
    for (int i = LOOP_DEPTH - 1; i >= 0; i--) begin
      if (chain && LVW'(i + 1) == lvl_d) begin
        if (pc_q == end_q[i]) begin
          if (cnt_q[i] > CNTW'(1)) begin
            cnt_d[i] = cnt_q[i] - CNTW'(1);
            redir    = 1'b1;
            redir_pc = head_q[i];
            chain    = 1'b0;
          end else begin
            lvl_d = LVW'(i);
          end
        end else begin
          chain = 1'b0;
        end
      end
    end

    npc = seq;
    if (redir) begin
      npc = redir_pc;
    end else if (halt) begin
      npc = pc_q;
    end else if (jump || call) begin
      npc = tgt;
      if (call) begin
        if (sp_q == SPW'(STACK_DEPTH)) begin
          so_set = 1'b1;
        end else begin
          for (int i = 0; i < STACK_DEPTH; i++)
            if (SPW'(i) == sp_q) stk_d[i] = seq;
          sp_d = sp_q + SPW'(1);
        end
      end
    end else if (ret) begin
      if (sp_q == '0) begin
        npc    = AW'(RST_VEC);
        su_set = 1'b1;
      end else begin
        npc  = top;
        sp_d = sp_q - SPW'(1);
      end
    end else if (iret) begin
      npc      = pi_q;
      in_irq_d = 1'b0;
    end

    if (do_start && !halt) begin
      if (lvl_d == LVW'(LOOP_DEPTH)) begin
        lo_set = 1'b1;
      end else begin
        for (int i = 0; i < LOOP_DEPTH; i++) begin
          if (LVW'(i) == lvl_d) begin
            head_d[i] = seq;
            end_d[i]  = pc_q + AW'(len);
            cnt_d[i]  = cnt1;
          end
        end
        lvl_d = lvl_d + LVW'(1);
      end
    end

    pc_d = npc;
    if (irq && !in_irq_q && !halt && !no_int && lvl_q == '0) begin
      pc_d     = AW'(IRQ_VEC);
      pi_d     = npc;
      in_irq_d = 1'b1;
      iack_d   = 1'b1;
    end

    stk_ovf_d  = so_set | (stk_ovf_q  & ~err_clr);
    stk_unf_d  = su_set | (stk_unf_q  & ~err_clr);
    loop_ovf_d = lo_set | (loop_ovf_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= AW'(RST_VEC);
      pi_q       <= '0;
      iack_q     <= 1'b0;
      in_irq_q   <= 1'b0;
      sp_q       <= '0;
      lvl_q      <= '0;
      stk_ovf_q  <= 1'b0;
      stk_unf_q  <= 1'b0;
      loop_ovf_q <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stk_q[i] <= '0;
      for (int i = 0; i < LOOP_DEPTH; i++) begin
        head_q[i] <= '0;
        end_q[i]  <= '0;
        cnt_q[i]  <= '0;
      end
    end else if (cen) begin
      pc_q       <= pc_d;
      pi_q       <= pi_d;
      iack_q     <= iack_d;
      in_irq_q   <= in_irq_d;
      sp_q       <= sp_d;
      lvl_q      <= lvl_d;
      stk_ovf_q  <= stk_ovf_d;
      stk_unf_q  <= stk_unf_d;
      loop_ovf_q <= loop_ovf_d;
      stk_q      <= stk_d;
      head_q     <= head_d;
      end_q      <= end_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pc       = pc_q;
  assign pi       = pi_q;
  assign iack     = iack_q;
  assign in_irq   = in_irq_q;
  assign sp       = sp_q;
  assign loop_lvl = lvl_q;
  assign stk_ovf  = stk_ovf_q;
  assign stk_unf  = stk_unf_q;
  assign loop_ovf = loop_ovf_q;
endmodule
